// File: rtl/ip_packet_rx.sv
// Ethernet/IPv4 receive filter: parses a MAC byte stream, drops frames not addressed
// to the accelerator and hands the sender addresses plus a 10-bit message downstream.
module ip_packet_rx #(
  parameter int AXI_S_DATA_WIDTH = 8,
  parameter int IP_ADDR_WIDTH    = 32,
  parameter int MAC_ADDR_WIDTH   = 48,
  parameter int ACCEL_DATA_WIDTH = 10
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [IP_ADDR_WIDTH-1:0]    ACCELERATOR_IP_ADDRESS,
  input  logic [MAC_ADDR_WIDTH-1:0]   ACCELERATOR_MAC_ADDRESS,
  input  logic [AXI_S_DATA_WIDTH-1:0] MAC_DATA_IN,
  input  logic                        MAC_DATA_VALID,
  input  logic                        MAC_DATA_FIRST,
  input  logic                        MAC_DATA_LAST,
  output logic                        MAC_DATA_READY,
  output logic [IP_ADDR_WIDTH-1:0]    SENDER_IP_ADDRESS,
  output logic [MAC_ADDR_WIDTH-1:0]   SENDER_MAC_ADDRESS,
  output logic [ACCEL_DATA_WIDTH-1:0] SENDER_MESSAGE,
  output logic                        MSG_VALID,
  input  logic                        MSG_READY,
  output logic [7:0]                  DROP_COUNT
);
  localparam int BW      = AXI_S_DATA_WIDTH;
  localparam int HI_BITS = ACCEL_DATA_WIDTH - BW;
  localparam logic [5:0] IDX_MAX = 6'd36;

  typedef enum logic [2:0] {
    IDLE,
    RX_ETH_HDR,
    RX_IP_HDR,
    RX_USER_DATA,
    DROP,
    DELIVER
  } state_t;

  state_t state, next_state;
  logic [5:0] byte_idx, cur_idx;
  logic [MAC_ADDR_WIDTH-BW-1:0] dst_mac_lo;
  logic [MAC_ADDR_WIDTH-1:0] src_mac, dst_mac_full;
  logic [IP_ADDR_WIDTH-BW-1:0] dst_ip_lo;
  logic [IP_ADDR_WIDTH-1:0] src_ip, dst_ip_full;
  logic [BW-1:0] eth_hi, byte35, msg_lo;
  logic [HI_BITS-1:0] byte34_lo;
  logic accept, in_frame, proc_en, restart, drop_end, fail, frame_drop, deliver_go;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;

  // A FIRST byte always starts a fresh frame as byte 0, whatever state we were in.
  assign accept       = MAC_DATA_VALID && MAC_DATA_READY;
  assign in_frame     = (state == RX_ETH_HDR) || (state == RX_IP_HDR) || (state == RX_USER_DATA);
  assign proc_en      = accept && (MAC_DATA_FIRST || in_frame);
  assign cur_idx      = MAC_DATA_FIRST ? 6'd0 : byte_idx;
  assign restart      = accept && MAC_DATA_FIRST && (in_frame || state == DROP);
  assign drop_end     = accept && !MAC_DATA_FIRST && MAC_DATA_LAST && (state == DROP);
  assign dst_mac_full = {dst_mac_lo, MAC_DATA_IN};
  assign dst_ip_full  = {dst_ip_lo, MAC_DATA_IN};
  assign msg_lo       = (cur_idx == 6'd35) ? MAC_DATA_IN : byte35;

  always_comb begin
    fail = 1'b0;
    case (cur_idx)
      6'd5:  fail = (dst_mac_full != ACCELERATOR_MAC_ADDRESS) &&
                    (dst_mac_full != {MAC_ADDR_WIDTH{1'b1}});
      6'd13: fail = ({eth_hi, MAC_DATA_IN} != 16'h0800);
      6'd14: fail = (MAC_DATA_IN != 8'h45);
      6'd33: fail = (dst_ip_full != ACCELERATOR_IP_ADDRESS);
      default: fail = 1'b0;
    endcase
  end

  assign frame_drop = proc_en && MAC_DATA_LAST && ((cur_idx < 6'd35) || fail);
  assign deliver_go = proc_en && MAC_DATA_LAST && !frame_drop;
  assign drop_inc   = 2'(restart) + 2'(frame_drop) + 2'(drop_end);
  assign drop_sum   = {1'b0, DROP_COUNT} + 9'(drop_inc);

  always_comb begin
    next_state = state;
    if (state == DELIVER) begin
      if (MSG_VALID && MSG_READY) next_state = IDLE;
    end else if (proc_en) begin
      if (MAC_DATA_LAST)        next_state = deliver_go ? DELIVER : IDLE;
      else if (fail)            next_state = DROP;
      else if (cur_idx < 6'd13) next_state = RX_ETH_HDR;
      else if (cur_idx < 6'd33) next_state = RX_IP_HDR;
      else                      next_state = RX_USER_DATA;
    end else if (drop_end) begin
      next_state = IDLE;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state              <= IDLE;
      byte_idx           <= '0;
      dst_mac_lo         <= '0;
      src_mac            <= '0;
      dst_ip_lo          <= '0;
      src_ip             <= '0;
      eth_hi             <= '0;
      byte34_lo          <= '0;
      byte35             <= '0;
      MAC_DATA_READY     <= 1'b1;
      MSG_VALID          <= 1'b0;
      SENDER_IP_ADDRESS  <= '0;
      SENDER_MAC_ADDRESS <= '0;
      SENDER_MESSAGE     <= '0;
      DROP_COUNT         <= '0;
    end else begin
      state          <= next_state;
      MAC_DATA_READY <= (next_state != DELIVER);
      DROP_COUNT     <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

      if (next_state == RX_ETH_HDR || next_state == RX_IP_HDR || next_state == RX_USER_DATA) begin
        if (proc_en) byte_idx <= (cur_idx == IDX_MAX) ? IDX_MAX : cur_idx + 6'd1;
      end else begin
        byte_idx <= '0;
      end

      // Header fields are shifted in MSB first as their bytes go by.
      if (proc_en) begin
        if (cur_idx <= 6'd5)
          dst_mac_lo <= dst_mac_full[MAC_ADDR_WIDTH-BW-1:0];
        else if (cur_idx <= 6'd11)
          src_mac <= {src_mac[MAC_ADDR_WIDTH-BW-1:0], MAC_DATA_IN};
        else if (cur_idx == 6'd12)
          eth_hi <= MAC_DATA_IN;
        else if (cur_idx >= 6'd26 && cur_idx <= 6'd29)
          src_ip <= {src_ip[IP_ADDR_WIDTH-BW-1:0], MAC_DATA_IN};
        else if (cur_idx >= 6'd30 && cur_idx <= 6'd32)
          dst_ip_lo <= dst_ip_full[IP_ADDR_WIDTH-BW-1:0];
        else if (cur_idx == 6'd34)
          byte34_lo <= MAC_DATA_IN[HI_BITS-1:0];
        else if (cur_idx == 6'd35)
          byte35 <= MAC_DATA_IN;
      end

      if (deliver_go) begin
        MSG_VALID          <= 1'b1;
        SENDER_IP_ADDRESS  <= src_ip;
        SENDER_MAC_ADDRESS <= src_mac;
        SENDER_MESSAGE     <= {byte34_lo, msg_lo};
      end else if (state == DELIVER && MSG_READY) begin
        MSG_VALID <= 1'b0;
      end
    end
  end
endmodule
